// File: rtl/regfile_2w2r_fwd.sv
// regfile_2w2r_fwd: DEPTH x WIDTH register file with two write ports and two
// combinational read ports. Optional same-cycle write-to-read forwarding.
// Also holds a per-register busy scoreboard for RAW hazard detection.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   reg1n/reg2n             read addresses
//   reg1o/reg2o             read data (combinational)
//   reg1_busy/reg2_busy     scoreboard bit for each read address (combinational)
//   wen0/wregn0/wdata0      write port 0 (ALU result)
//   wen1/wregn1/wdata1      write port 1 (load result, wins on address collision)
//   mark_en/mark_regn       set busy bit when decode issues a producer
// Register 0 always reads 0, is never busy, and ignores writes and marks.
module regfile_2w2r_fwd #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned AW     = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    reg1n,
  input  logic [AW-1:0]    reg2n,
  output logic [WIDTH-1:0] reg1o,
  output logic [WIDTH-1:0] reg2o,
  output logic             reg1_busy,
  output logic             reg2_busy,
  input  logic             wen0,
  input  logic [AW-1:0]    wregn0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             wen1,
  input  logic [AW-1:0]    wregn1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             mark_en,
  input  logic [AW-1:0]    mark_regn
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Qualified write/mark strobes: anything addressed to register 0 is dropped.
  logic w0_c, w1_c, mk_c;
  assign w0_c = wen0 && (wregn0 != '0);
  assign w1_c = wen1 && (wregn1 != '0);
  assign mk_c = mark_en && (mark_regn != '0);

  // Next-state for array and scoreboard. Port 1 is applied after port 0, so it
  // wins a same-address collision; the mark is applied last so a new producer
  // supersedes a retiring one.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (w0_c) begin
      regs_d[wregn0] = wdata0;
      busy_d[wregn0] = 1'b0;
    end
    if (w1_c) begin
      regs_d[wregn1] = wdata1;
      busy_d[wregn1] = 1'b0;
    end
    if (mk_c) begin
      busy_d[mark_regn] = 1'b1;
    end
  end

  // State registers; reset overrides any write or mark in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // One read port: returns {busy, data}. With BYPASS, an enabled same-cycle
  // write to the address is forwarded and masks the busy bit.
  function automatic logic [WIDTH:0] rd_port(
    input logic [AW-1:0]    a,
    input logic [WIDTH-1:0] stored,
    input logic             busy
  );
    logic [WIDTH-1:0] data;
    logic             bsy;
    logic             hit0;
    logic             hit1;
    data = stored;
    bsy  = busy;
    hit0 = w0_c && (wregn0 == a);
    hit1 = w1_c && (wregn1 == a);
    if (BYPASS) begin
      if (hit1) begin
        data = wdata1;
      end else if (hit0) begin
        data = wdata0;
      end
      if (hit0 || hit1) begin
        bsy = 1'b0;
      end
    end
    if (a == '0) begin
      data = '0;
      bsy  = 1'b0;
    end
    return {bsy, data};
  endfunction

  assign {reg1_busy, reg1o} = rd_port(reg1n, regs_q[reg1n], busy_q[reg1n]);
  assign {reg2_busy, reg2o} = rd_port(reg2n, regs_q[reg2n], busy_q[reg2n]);

endmodule

// File: tb/tb_regfile_2w2r_fwd.sv
// Directed bench for regfile_2w2r_fwd: default (BYPASS=1), BYPASS=0 and a
// narrow WIDTH=16/AW=3 instance, all driven from one linear initial block.
module tb_regfile_2w2r_fwd;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  reg1n, reg2n, wregn0, wregn1, mark_regn;
  logic [31:0] wdata0, wdata1;
  logic        wen0, wen1, mark_en;

  logic [31:0] a_r1, a_r2, b_r1, b_r2;
  logic        a_b1, a_b2, b_b1, b_b2;

  logic [2:0]  s_reg1n, s_reg2n, s_wregn0, s_wregn1, s_mark_regn;
  logic [15:0] s_wdata0, s_wdata1, s_r1, s_r2;
  logic        s_wen0, s_wen1, s_mark_en, s_b1, s_b2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_2w2r_fwd dut_a (
    .clk(clk), .reset(reset), .reg1n(reg1n), .reg2n(reg2n),
    .reg1o(a_r1), .reg2o(a_r2), .reg1_busy(a_b1), .reg2_busy(a_b2),
    .wen0(wen0), .wregn0(wregn0), .wdata0(wdata0),
    .wen1(wen1), .wregn1(wregn1), .wdata1(wdata1),
    .mark_en(mark_en), .mark_regn(mark_regn)
  );

  regfile_2w2r_fwd #(.BYPASS(1'b0)) dut_b (
    .clk(clk), .reset(reset), .reg1n(reg1n), .reg2n(reg2n),
    .reg1o(b_r1), .reg2o(b_r2), .reg1_busy(b_b1), .reg2_busy(b_b2),
    .wen0(wen0), .wregn0(wregn0), .wdata0(wdata0),
    .wen1(wen1), .wregn1(wregn1), .wdata1(wdata1),
    .mark_en(mark_en), .mark_regn(mark_regn)
  );

  regfile_2w2r_fwd #(.WIDTH(16), .AW(3)) dut_s (
    .clk(clk), .reset(reset), .reg1n(s_reg1n), .reg2n(s_reg2n),
    .reg1o(s_r1), .reg2o(s_r2), .reg1_busy(s_b1), .reg2_busy(s_b2),
    .wen0(s_wen0), .wregn0(s_wregn0), .wdata0(s_wdata0),
    .wen1(s_wen1), .wregn1(s_wregn1), .wdata1(s_wdata1),
    .mark_en(s_mark_en), .mark_regn(s_mark_regn)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen0 = 1'b0; wregn0 = '0; wdata0 = '0;
    wen1 = 1'b0; wregn1 = '0; wdata1 = '0;
    mark_en = 1'b0; mark_regn = '0;
    s_wen0 = 1'b0; s_wregn0 = '0; s_wdata0 = '0;
    s_wen1 = 1'b0; s_wregn1 = '0; s_wdata1 = '0;
    s_mark_en = 1'b0; s_mark_regn = '0;
  endtask

  initial begin
    idle();
    reg1n = '0; reg2n = '0; s_reg1n = '0; s_reg2n = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    reg1n = 5'd5; reg2n = 5'd31; #1;
    chk("rst_r1", a_r1, 32'h0);
    chk("rst_r2", a_r2, 32'h0);
    chk("rst_b1", 32'(a_b1), 32'h0);
    chk("rst_b2", 32'(a_b2), 32'h0);

    // Basic write then read
    wen0 = 1'b1; wregn0 = 5'd2; wdata0 = 32'hABCD1234;
    tick(); idle();
    reg1n = 5'd2; reg2n = 5'd2; #1;
    chk("wr2_r1", a_r1, 32'hABCD1234);
    chk("wr2_r2", a_r2, 32'hABCD1234);
    chk("wr2_b1", 32'(a_b1), 32'h0);
    chk("wr2_nb", b_r1, 32'hABCD1234);

    // Same-address collision: port 1 wins
    wen0 = 1'b1; wregn0 = 5'd7; wdata0 = 32'h11111111;
    wen1 = 1'b1; wregn1 = 5'd7; wdata1 = 32'h22222222;
    tick(); idle();
    reg1n = 5'd7; #1;
    chk("coll_a", a_r1, 32'h22222222);
    chk("coll_b", b_r1, 32'h22222222);

    // Different addresses: both written
    wen0 = 1'b1; wregn0 = 5'd3; wdata0 = 32'h33;
    wen1 = 1'b1; wregn1 = 5'd4; wdata1 = 32'h44;
    tick(); idle();
    reg1n = 5'd3; reg2n = 5'd4; #1;
    chk("dual_r3", a_r1, 32'h33);
    chk("dual_r4", a_r2, 32'h44);

    // Forwarding: port 1 beats port 0 on same address, port 0 alone forwards too
    wen1 = 1'b1; wregn1 = 5'd9; wdata1 = 32'hDEADBEEF;
    wen0 = 1'b1; wregn0 = 5'd9; wdata0 = 32'h12345678;
    reg1n = 5'd9; reg2n = 5'd9; #1;
    chk("fwd_p1_a", a_r1, 32'hDEADBEEF);
    chk("fwd_p1_b", b_r1, 32'h0);
    tick(); idle();
    wen0 = 1'b1; wregn0 = 5'd10; wdata0 = 32'h0000A5A5;
    reg2n = 5'd10; #1;
    chk("after_fwd9", a_r1, 32'hDEADBEEF);
    chk("fwd_p0_a", a_r2, 32'h0000A5A5);
    chk("fwd_p0_b", b_r2, 32'h0);
    tick(); idle();

    // Scoreboard: mark has no same-cycle effect, busy next cycle
    mark_en = 1'b1; mark_regn = 5'd31;
    reg1n = 5'd31; reg2n = 5'd31; #1;
    chk("mark_same", 32'(a_b1), 32'h0);
    tick(); idle(); #1;
    chk("mark_a1", 32'(a_b1), 32'h1);
    chk("mark_a2", 32'(a_b2), 32'h1);
    chk("mark_b1", 32'(b_b1), 32'h1);

    // Retiring write clears busy; forwarded with BYPASS=1
    wen0 = 1'b1; wregn0 = 5'd31; wdata0 = 32'h5; #1;
    chk("wbusy_a", 32'(a_b1), 32'h0);
    chk("wbusy_b", 32'(b_b1), 32'h1);
    chk("wdata_a", a_r1, 32'h5);
    chk("wdata_b", b_r1, 32'h0);
    tick(); idle(); #1;
    chk("clr_a", 32'(a_b1), 32'h0);
    chk("clr_b", 32'(b_b1), 32'h0);
    chk("r31_a", a_r1, 32'h5);

    // Mark and write same register: mark wins
    mark_en = 1'b1; mark_regn = 5'd31;
    wen0 = 1'b1; wregn0 = 5'd31; wdata0 = 32'h6; #1;
    chk("mw_same", 32'(a_b1), 32'h0);
    tick(); idle(); #1;
    chk("mw_a", 32'(a_b1), 32'h1);
    chk("mw_b", 32'(b_b1), 32'h1);
    chk("mw_data", a_r1, 32'h6);

    // Register 0 is hard-wired
    wen0 = 1'b1; wregn0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    wen1 = 1'b1; wregn1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    mark_en = 1'b1; mark_regn = 5'd0;
    reg1n = 5'd0; reg2n = 5'd0; #1;
    chk("r0_same_d", a_r1, 32'h0);
    chk("r0_same_b", 32'(a_b2), 32'h0);
    tick(); idle(); #1;
    chk("r0_next_d", a_r2, 32'h0);
    chk("r0_next_b", 32'(a_b1), 32'h0);
    chk("r0_next_nb", b_r1, 32'h0);

    // Fill 1..31 with index, two per cycle
    for (int i = 1; i < 32; i += 2) begin
      wen0 = 1'b1; wregn0 = 5'(i); wdata0 = 32'(i);
      wen1 = (i < 31); wregn1 = 5'(i + 1); wdata1 = 32'(i + 1);
      tick();
    end
    idle();
    reg1n = 5'd17; reg2n = 5'd30; #1;
    chk("fill17", a_r1, 32'd17);
    chk("fill30", b_r2, 32'd30);
    mark_en = 1'b1; mark_regn = 5'd5; tick();
    mark_regn = 5'd20; tick(); idle();
    reg1n = 5'd5; reg2n = 5'd20; #1;
    chk("busy5", 32'(a_b1), 32'h1);
    chk("busy20", 32'(b_b2), 32'h1);

    // Reset mid-operation with a pending write and mark: all lost
    reset = 1'b1;
    wen0 = 1'b1; wregn0 = 5'd12; wdata0 = 32'h00000BAD;
    mark_en = 1'b1; mark_regn = 5'd13;
    tick();
    reset = 1'b0; idle();
    for (int i = 0; i < 32; i++) begin
      reg1n = 5'(i); reg2n = 5'(31 - i); #1;
      chk($sformatf("clr_r1_%0d", i), a_r1, 32'h0);
      chk($sformatf("clr_b1_%0d", i), 32'(a_b1), 32'h0);
      chk($sformatf("clr_nb_%0d", i), b_r2, 32'h0);
      chk($sformatf("clr_nbb_%0d", i), 32'(b_b2), 32'h0);
    end

    // Narrow instance: WIDTH=16, AW=3
    s_wen0 = 1'b1; s_wregn0 = 3'd7; s_wdata0 = 16'hBEEF;
    s_reg1n = 3'd7; #1;
    chk("s_fwd7", 32'(s_r1), 32'h0000BEEF);
    tick(); idle(); #1;
    chk("s_rd7", 32'(s_r1), 32'h0000BEEF);
    s_mark_en = 1'b1; s_mark_regn = 3'd3; tick(); idle();
    s_reg2n = 3'd3; #1;
    chk("s_busy3", 32'(s_b2), 32'h1);
    s_wen1 = 1'b1; s_wregn1 = 3'd3; s_wdata1 = 16'h1234; #1;
    chk("s_fwd3", 32'(s_r2), 32'h00001234);
    chk("s_fwdb3", 32'(s_b2), 32'h0);
    tick(); idle(); #1;
    chk("s_rd3", 32'(s_r2), 32'h00001234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout observed no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
